// File: rtl/mult_huit_pkg.sv
// Shared types and constants for the mult_huit shift-and-add multiplier.
// Optional feature macro: MULT_HUIT_ZERO_SKIP_EN (see mult_huit.sv).
package mult_huit_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mult_huit_state_e;

   localparam int MULT_HUIT_W    = 8;
   localparam int MULT_HUIT_ITER = 8;
   localparam int MULT_HUIT_CW   = $clog2(MULT_HUIT_ITER);

   localparam logic [MULT_HUIT_CW-1:0] MULT_HUIT_LAST = MULT_HUIT_CW'(MULT_HUIT_ITER - 1);

endpackage

// File: rtl/add_huit.sv
// 8-bit ripple-carry adder with carry-in and carry-out.
module add_huit
   import mult_huit_pkg::*;
(
   input  logic [MULT_HUIT_W-1:0] a,
   input  logic [MULT_HUIT_W-1:0] b,
   input  logic                   rin,
   output logic [MULT_HUIT_W-1:0] sum,
   output logic                   rout
);

   logic [MULT_HUIT_W:0] c;

   always_comb begin
      c    = '0;
      sum  = '0;
      c[0] = rin;
      for (int unsigned i = 0; i < MULT_HUIT_W; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
      rout = c[MULT_HUIT_W];
   end

endmodule

// File: rtl/mult_huit.sv
// Sequential 8x8 unsigned shift-and-add multiplier built on add_huit.
// Define MULT_HUIT_ZERO_SKIP_EN to finish zero-operand requests in one cycle.
module mult_huit
   import mult_huit_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   p
);

   if (WIDTH != MULT_HUIT_W) begin : g_bad_width
      $error("mult_huit: WIDTH must be 8 to match add_huit");
   end

   mult_huit_state_e          state, state_nxt;
   logic [WIDTH-1:0]          mcand, hi, lo;
   logic [MULT_HUIT_CW-1:0]   cnt;
   logic [2*WIDTH-1:0]        p_q;
   logic [WIDTH-1:0]          add_b, sum;
   logic                      rout;
   logic [2*WIDTH-1:0]        shifted;
   logic                      last;

   assign add_b   = lo[0] ? mcand : '0;
   assign shifted = {rout, sum, lo[WIDTH-1:1]};
   assign last    = (cnt == MULT_HUIT_LAST);

   add_huit u_add (
      .a    (hi),
      .b    (add_b),
      .rin  (1'b0),
      .sum  (sum),
      .rout (rout)
   );

`ifdef MULT_HUIT_ZERO_SKIP_EN
   logic zero_op;
   assign zero_op = (a == '0) || (b == '0);
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) begin
`ifdef MULT_HUIT_ZERO_SKIP_EN
               state_nxt = zero_op ? DONE : BUSY;
`else
               state_nxt = BUSY;
`endif
            end
         end
         BUSY:    if (last) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Carry-out of each add becomes the MSB of the 17-bit right shift.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mcand <= '0;
         hi    <= '0;
         lo    <= '0;
         cnt   <= '0;
         p_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mcand <= a;
                  lo    <= b;
                  hi    <= '0;
                  cnt   <= '0;
`ifdef MULT_HUIT_ZERO_SKIP_EN
                  if (zero_op) p_q <= '0;
`endif
               end
            end
            BUSY: begin
               {hi, lo} <= shifted;
               cnt      <= cnt + 1'b1;
               if (last) p_q <= shifted;
            end
            default: ;
         endcase
      end
   end

   assign busy = (state == BUSY);
   assign done = (state == DONE);
   assign p    = p_q;

endmodule
